// File: rtl/enc_binder_array_pkg.sv
// Shared encoder package: default dimensions, default per-feature shift
// table and the FSM state encoding used by the binder array.
package enc_binder_array_pkg;

  // Default hypervector width in bits.
  localparam int ENC_HV_DIM = 1024;

  // Default number of features bound per clock (physical rotator lanes).
  localparam int FEATURES_PER_CC = 4;

  // Default number of level hypervectors bound per encoding.
  localparam int DEFAULT_FEATURES = 8;

  // Default shift table: feature i is rotated by i positions.
  localparam int DEFAULT_SHIFT [DEFAULT_FEATURES] = '{0, 1, 2, 3, 4, 5, 6, 7};

  // Binder sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Integer ceiling division, used to size the beat counter.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/enc_binder_array_rotator.sv
// Combinational barrel rotator for one hypervector lane.
// Left:  rot[n] = hv[(n - s) mod HV_DIM]
// Right: rot[n] = hv[(n + s) mod HV_DIM]
// with s = amt mod HV_DIM. The modulo only matters for non power-of-two
// widths; for power-of-two widths amt already fits below HV_DIM.
module enc_rotator
  import enc_binder_array_pkg::*;
#(
  parameter  int HV_DIM  = ENC_HV_DIM,
  localparam int SHIFT_W = $clog2(HV_DIM)
) (
  input  logic [HV_DIM-1:0]  hv,
  input  logic [SHIFT_W-1:0] amt,
  input  logic               dir,
  output logic [HV_DIM-1:0]  rot
);

  localparam logic [SHIFT_W:0] DIM_W = (SHIFT_W + 1)'(HV_DIM);

  logic [SHIFT_W-1:0] s;
  logic [HV_DIM-1:0]  v;

  // Reduce the requested amount into the range 0 .. HV_DIM-1.
  assign s = SHIFT_W'({1'b0, amt} % DIM_W);

  // Log-depth rotator: stage k rotates by 2**k when bit k of s is set.
  always_comb begin
    v = hv;
    for (int k = 0; k < SHIFT_W; k++) begin
      if (s[k]) begin
        if (dir) begin
          v = (v >> (1 << k)) | (v << (HV_DIM - (1 << k)));
        end else begin
          v = (v << (1 << k)) | (v >> (HV_DIM - (1 << k)));
        end
      end
    end
    rot = v;
  end

endmodule

// File: rtl/enc_binder_array.sv
// Binder array: snapshots FEATURES level hypervectors with per-feature
// rotate amounts, then streams the rotated (bound) vectors out LANES at a
// time, one beat per cycle under a valid/ready handshake.
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_hv, out_lane_valid,
// out_beat and out_last are held. out_valid never drops without a transfer
// except on reset.
module enc_binder_array
  import enc_binder_array_pkg::*;
#(
  parameter  int HV_DIM   = ENC_HV_DIM,
  parameter  int FEATURES = DEFAULT_FEATURES,
  parameter  int LANES    = FEATURES_PER_CC,
  localparam int BEATS    = ceil_div(FEATURES, LANES),
  localparam int SHIFT_W  = $clog2(HV_DIM),
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        en,
  input  logic                        dir,
  input  logic [FEATURES*HV_DIM-1:0]  level_hv,
  input  logic [FEATURES*SHIFT_W-1:0] shift_amt,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*HV_DIM-1:0]     out_hv,
  output logic [LANES-1:0]            out_lane_valid,
  output logic [BEAT_W-1:0]           out_beat,
  output logic                        out_last,
  output logic                        done,
  output logic [1:0]                  state_dbg
);

  state_t                      state;
  logic [BEAT_W-1:0]           beat_cnt;
  logic [FEATURES*HV_DIM-1:0]  snap_hv;
  logic [FEATURES*SHIFT_W-1:0] snap_amt;
  logic                        snap_dir;

  logic [LANES*HV_DIM-1:0]     next_hv;
  logic [LANES-1:0]            next_mask;
  logic                        last_beat;
  logic                        load_beat;
  int                          beat_base;

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign beat_base = int'(beat_cnt) * LANES;
  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  assign load_beat = en && (!out_valid || out_ready);

  // One rotator per lane, fed from the snapshot of the current beat.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [HV_DIM-1:0]  lane_in;
    logic [SHIFT_W-1:0] lane_amt;
    logic               lane_ok;
    logic [HV_DIM-1:0]  lane_rot;

    // Select feature beat*LANES+j; lanes past the last feature stay zero.
    always_comb begin
      lane_in  = '0;
      lane_amt = '0;
      lane_ok  = 1'b0;
      if (beat_base + j < FEATURES) begin
        lane_ok  = 1'b1;
        lane_in  = snap_hv[(beat_base + j)*HV_DIM +: HV_DIM];
        lane_amt = snap_amt[(beat_base + j)*SHIFT_W +: SHIFT_W];
      end
    end

    enc_rotator #(
      .HV_DIM (HV_DIM)
    ) u_rot (
      .hv  (lane_in),
      .amt (lane_amt),
      .dir (snap_dir),
      .rot (lane_rot)
    );

    assign next_hv[j*HV_DIM +: HV_DIM] = lane_ok ? lane_rot : '0;
    assign next_mask[j]                = lane_ok;
  end

  // Sequencer: snapshot on start, emit beats, flush the last one, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      snap_hv        <= '0;
      snap_amt       <= '0;
      snap_dir       <= 1'b0;
      out_valid      <= 1'b0;
      out_hv         <= '0;
      out_lane_valid <= '0;
      out_beat       <= '0;
      out_last       <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && en) begin
            snap_hv  <= level_hv;
            snap_amt <= shift_amt;
            snap_dir <= dir;
            beat_cnt <= '0;
            state    <= RUN;
          end
        end

        RUN: begin
          if (load_beat) begin
            out_valid      <= 1'b1;
            out_hv         <= next_hv;
            out_lane_valid <= next_mask;
            out_beat       <= beat_cnt;
            out_last       <= last_beat;
            if (last_beat) begin
              state <= FLUSH;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end else if (out_valid && out_ready) begin
            // Paused by en: the presented beat was taken, nothing replaces it.
            out_valid <= 1'b0;
          end
        end

        FLUSH: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_binder_array.sv
// Bench for enc_binder_array: two instances (8 features and 6 features,
// both HV_DIM=16, LANES=4) with an expected-beat queue per instance.
module tb_enc_binder_array;
  import enc_binder_array_pkg::*;

  localparam int D  = 16;
  localparam int SW = 4;
  localparam int L  = 4;
  localparam int FA = 8;
  localparam int FB = 6;
  localparam int EW = 1 + 1 + L + L*D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- instance A (8 features) ----------------
  logic            a_start, a_en, a_dir, a_busy, a_out_valid, a_out_ready, a_out_last, a_done;
  logic [FA*D-1:0] a_level;
  logic [FA*SW-1:0] a_shift;
  logic [L*D-1:0]  a_out_hv;
  logic [L-1:0]    a_out_lane_valid;
  logic [0:0]      a_out_beat;
  logic [1:0]      a_state;

  enc_binder_array #(.HV_DIM(D), .FEATURES(FA), .LANES(L)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .en(a_en), .dir(a_dir),
    .level_hv(a_level), .shift_amt(a_shift), .busy(a_busy),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_hv(a_out_hv),
    .out_lane_valid(a_out_lane_valid), .out_beat(a_out_beat),
    .out_last(a_out_last), .done(a_done), .state_dbg(a_state)
  );

  // ---------------- instance B (6 features) ----------------
  logic            b_start, b_en, b_dir, b_busy, b_out_valid, b_out_ready, b_out_last, b_done;
  logic [FB*D-1:0] b_level;
  logic [FB*SW-1:0] b_shift;
  logic [L*D-1:0]  b_out_hv;
  logic [L-1:0]    b_out_lane_valid;
  logic [0:0]      b_out_beat;
  logic [1:0]      b_state;

  enc_binder_array #(.HV_DIM(D), .FEATURES(FB), .LANES(L)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .en(b_en), .dir(b_dir),
    .level_hv(b_level), .shift_amt(b_shift), .busy(b_busy),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_hv(b_out_hv),
    .out_lane_valid(b_out_lane_valid), .out_beat(b_out_beat),
    .out_last(b_out_last), .done(b_done), .state_dbg(b_state)
  );

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [EW-1:0] a_exp_q[$];
  logic [EW-1:0] b_exp_q[$];
  logic [EW-1:0] a_exp, b_exp;
  int a_done_cnt = 0;
  int b_done_cnt = 0;

  logic [D-1:0] lv_a [FA];
  int           sh_a [FA];
  logic [D-1:0] lv_b [FA];
  int           sh_b [FA];

  // Reference rotate, bit by bit from the index formula.
  function automatic logic [D-1:0] rot_model(input logic [D-1:0] v, input int s, input logic d);
    logic [D-1:0] r;
    int sm;
    sm = s % D;
    for (int n = 0; n < D; n++) begin
      r[n] = d ? v[(n + sm) % D] : v[(n - sm + D) % D];
    end
    return r;
  endfunction

  // Expected {last, beat, mask, hv} for beat b of an nf-feature encoding.
  function automatic logic [EW-1:0] exp_entry(input int b, input int nf, input logic d,
                                               input logic [D-1:0] lv [FA], input int sh [FA]);
    logic [L*D-1:0] hv;
    logic [L-1:0]   m;
    logic           last;
    int i;
    hv = '0;
    m  = '0;
    for (int j = 0; j < L; j++) begin
      i = b*L + j;
      if (i < nf) begin
        hv[j*D +: D] = rot_model(lv[i], sh[i], d);
        m[j] = 1'b1;
      end
    end
    last = (b == (nf + L - 1)/L - 1);
    return {last, 1'(b), m, hv};
  endfunction

  // Monitors: compare every accepted beat against the queue head.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      tests_run++;
      if (a_exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL a_beat unexpected beat got beat=%0d hv=%h exp none", a_out_beat, a_out_hv);
      end else begin
        a_exp = a_exp_q.pop_front();
        if ({a_out_last, a_out_beat, a_out_lane_valid, a_out_hv} !== a_exp) begin
          tests_failed++;
          $display("FAIL a_beat got %h exp %h", {a_out_last, a_out_beat, a_out_lane_valid, a_out_hv}, a_exp);
        end
      end
    end
    if (!rst && a_done) a_done_cnt++;
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      tests_run++;
      if (b_exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL b_beat unexpected beat got beat=%0d hv=%h exp none", b_out_beat, b_out_hv);
      end else begin
        b_exp = b_exp_q.pop_front();
        if ({b_out_last, b_out_beat, b_out_lane_valid, b_out_hv} !== b_exp) begin
          tests_failed++;
          $display("FAIL b_beat got %h exp %h", {b_out_last, b_out_beat, b_out_lane_valid, b_out_hv}, b_exp);
        end
      end
    end
    if (!rst && b_done) b_done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    for (int i = 0; i < FA; i++) begin
      a_level[i*D +: D]   = lv_a[i];
      a_shift[i*SW +: SW] = SW'(sh_a[i]);
    end
    for (int b = 0; b < 2; b++) a_exp_q.push_back(exp_entry(b, FA, a_dir, lv_a, sh_a));
    a_en    = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic start_b();
    for (int i = 0; i < FB; i++) begin
      b_level[i*D +: D]   = lv_b[i];
      b_shift[i*SW +: SW] = SW'(sh_b[i]);
    end
    for (int b = 0; b < 2; b++) b_exp_q.push_back(exp_entry(b, FB, b_dir, lv_b, sh_b));
    b_en    = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
  endtask

  task automatic wait_done_a(input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (rnd) begin
        a_out_ready = 1'($urandom_range(0, 1));
        a_en        = 1'($urandom_range(0, 1));
      end
      tick();
      if (a_done) begin
        seen = 1'b1;
        break;
      end
    end
    a_en        = 1'b1;
    a_out_ready = 1'b1;
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL a_done_timeout got 0 exp 1");
    end
  endtask

  task automatic check_drained_a(input string name, input int exp_done);
    tick();
    tick();
    tests_run++;
    if (a_exp_q.size() != 0 || a_done_cnt != exp_done || a_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_drain got q=%0d done=%0d busy=%b exp q=0 done=%0d busy=0",
               name, a_exp_q.size(), a_done_cnt, a_busy, exp_done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    a_start = 1'b1; a_en = 1'b1;
    tick();
    tick();
    tests_run++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_out_last !== 1'b0 ||
        a_out_lane_valid !== '0 || a_out_beat !== '0 || a_out_hv !== '0 || a_state !== 2'(IDLE)) begin
      tests_failed++;
      $display("FAIL reset_outputs got v=%b busy=%b done=%b last=%b mask=%b beat=%0d hv=%h st=%0d exp all zero",
               a_out_valid, a_busy, a_done, a_out_last, a_out_lane_valid, a_out_beat, a_out_hv, a_state);
    end
    a_start = 1'b0;
    rst = 1'b0;
    tick();
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_over_start got busy=%b exp 0", a_busy);
    end
  endtask

  task automatic test_basic();
    int d0;
    d0 = a_done_cnt;
    a_out_ready = 1'b1;
    a_dir = 1'b0;
    for (int i = 0; i < FA; i++) begin
      lv_a[i] = 16'h0001;
      sh_a[i] = i;
    end
    start_a();
    tests_run++;
    if (a_busy !== 1'b1 || a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_latency got busy=%b valid=%b exp busy=1 valid=0", a_busy, a_out_valid);
    end
    tick();
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_beat !== 1'b0 || a_out_last !== 1'b0 ||
        a_out_hv !== 64'h0008_0004_0002_0001 || a_out_lane_valid !== 4'hf) begin
      tests_failed++;
      $display("FAIL basic_beat0 got v=%b beat=%0d last=%b hv=%h exp v=1 beat=0 last=0 hv=0008000400020001",
               a_out_valid, a_out_beat, a_out_last, a_out_hv);
    end
    tick();
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_beat !== 1'b1 || a_out_last !== 1'b1 ||
        a_out_hv !== 64'h0080_0040_0020_0010) begin
      tests_failed++;
      $display("FAIL basic_beat1 got v=%b beat=%0d last=%b hv=%h exp v=1 beat=1 last=1 hv=0080004000200010",
               a_out_valid, a_out_beat, a_out_last, a_out_hv);
    end
    tick();
    tests_run++;
    if (a_done !== 1'b1 || a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done got done=%b valid=%b exp done=1 valid=0", a_done, a_out_valid);
    end
    tick();
    tests_run++;
    if (a_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_pulse got done=%b exp 0", a_done);
    end
    check_drained_a("basic", d0 + 1);
  endtask

  task automatic test_boundary();
    int d0;
    logic [D-1:0] exp1;
    d0 = a_done_cnt;
    a_out_ready = 1'b1;
    a_dir = 1'b0;
    for (int i = 0; i < FA; i++) begin
      lv_a[i] = D'($urandom_range(1, 16'hffff));
      sh_a[i] = (i % 2 == 0) ? 0 : D - 1;
    end
    exp1 = {lv_a[1][0], lv_a[1][D-1:1]};
    start_a();
    tick();
    tests_run++;
    if (a_out_hv[D-1:0] !== lv_a[0] || a_out_hv[2*D-1:D] !== exp1) begin
      tests_failed++;
      $display("FAIL boundary_shift got l0=%h l1=%h exp l0=%h l1=%h",
               a_out_hv[D-1:0], a_out_hv[2*D-1:D], lv_a[0], exp1);
    end
    wait_done_a(1'b0);
    check_drained_a("boundary", d0 + 1);
  endtask

  task automatic test_modulo();
    int d0;
    d0 = a_done_cnt;
    a_out_ready = 1'b1;
    a_dir = 1'b1;
    for (int i = 0; i < FA; i++) begin
      lv_a[i] = 16'h0001;
      sh_a[i] = 17;
    end
    start_a();
    tick();
    tests_run++;
    if (a_out_hv[D-1:0] !== 16'h8000) begin
      tests_failed++;
      $display("FAIL modulo_right got %h exp 8000", a_out_hv[D-1:0]);
    end
    wait_done_a(1'b0);
    check_drained_a("modulo", d0 + 1);
  endtask

  task automatic test_narrow();
    bit found;
    bit seen;
    int d0;
    d0 = b_done_cnt;
    found = 1'b0;
    seen  = 1'b0;
    b_out_ready = 1'b1;
    b_dir = 1'($urandom_range(0, 1));
    for (int i = 0; i < FA; i++) begin
      lv_b[i] = D'($urandom_range(1, 16'hffff));
      sh_b[i] = $urandom_range(0, D - 1);
    end
    start_b();
    for (int c = 0; c < 20; c++) begin
      tick();
      if (b_out_valid && b_out_beat == 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found || b_out_lane_valid !== 4'b0011 || b_out_hv[4*D-1:2*D] !== '0 || b_out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL narrow_beat1 got found=%b mask=%b hi=%h last=%b exp found=1 mask=0011 hi=0 last=1",
               found, b_out_lane_valid, b_out_hv[4*D-1:2*D], b_out_last);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (b_done) begin
        seen = 1'b1;
        break;
      end
    end
    tick();
    tick();
    tests_run++;
    if (!seen || b_exp_q.size() != 0 || b_done_cnt != d0 + 1) begin
      tests_failed++;
      $display("FAIL narrow_done got seen=%b q=%0d done=%0d exp seen=1 q=0 done=%0d",
               seen, b_exp_q.size(), b_done_cnt, d0 + 1);
    end
  endtask

  task automatic test_backpressure();
    int d0;
    logic [EW-1:0] held;
    d0 = a_done_cnt;
    a_out_ready = 1'b0;
    a_dir = 1'b0;
    for (int i = 0; i < FA; i++) begin
      lv_a[i] = D'($urandom_range(1, 16'hffff));
      sh_a[i] = $urandom_range(0, D - 1);
    end
    start_a();
    tick();
    held = {a_out_last, a_out_beat, a_out_lane_valid, a_out_hv};
    a_start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (a_out_valid !== 1'b1 || {a_out_last, a_out_beat, a_out_lane_valid, a_out_hv} !== held ||
          a_out_beat !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold cycle=%0d got v=%b %h exp v=1 %h", c, a_out_valid,
                 {a_out_last, a_out_beat, a_out_lane_valid, a_out_hv}, held);
      end
    end
    a_start = 1'b0;
    a_out_ready = 1'b1;
    tick();
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_beat !== 1'b1 || a_out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_b2b got v=%b beat=%0d last=%b exp v=1 beat=1 last=1",
               a_out_valid, a_out_beat, a_out_last);
    end
    tick();
    tests_run++;
    if (a_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_done got %b exp 1", a_done);
    end
    check_drained_a("stall", d0 + 1);
  endtask

  task automatic test_pause();
    int d0;
    d0 = a_done_cnt;
    a_out_ready = 1'b1;
    a_dir = 1'b1;
    for (int i = 0; i < FA; i++) begin
      lv_a[i] = D'($urandom_range(1, 16'hffff));
      sh_a[i] = $urandom_range(0, D - 1);
    end
    start_a();
    tick();
    a_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (a_out_valid !== 1'b0 || a_busy !== 1'b1 || a_out_beat !== 1'b0) begin
        tests_failed++;
        $display("FAIL pause_hold cycle=%0d got v=%b busy=%b beat=%0d exp v=0 busy=1 beat=0",
                 c, a_out_valid, a_busy, a_out_beat);
      end
    end
    a_en = 1'b1;
    tick();
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_beat !== 1'b1 || a_out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL pause_resume got v=%b beat=%0d last=%b exp v=1 beat=1 last=1",
               a_out_valid, a_out_beat, a_out_last);
    end
    wait_done_a(1'b0);
    check_drained_a("pause", d0 + 1);
  endtask

  task automatic test_reset_mid();
    int d0;
    a_out_ready = 1'b1;
    a_dir = 1'b0;
    for (int i = 0; i < FA; i++) begin
      lv_a[i] = D'($urandom_range(1, 16'hffff));
      sh_a[i] = $urandom_range(0, D - 1);
    end
    start_a();
    tick();
    tick();
    d0 = a_done_cnt;
    rst = 1'b1;
    tick();
    tests_run++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_abort got v=%b busy=%b done=%b exp 0 0 0", a_out_valid, a_busy, a_done);
    end
    rst = 1'b0;
    a_exp_q.delete();
    tick();
    tick();
    tests_run++;
    if (a_done_cnt != d0 || a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_nodone got done=%0d v=%b exp done=%0d v=0", a_done_cnt, a_out_valid, d0);
    end
    start_a();
    tick();
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_beat !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_restart got v=%b beat=%0d exp v=1 beat=0", a_out_valid, a_out_beat);
    end
    wait_done_a(1'b0);
    check_drained_a("rstmid", d0 + 1);
  endtask

  task automatic test_random();
    int d0;
    d0 = a_done_cnt;
    for (int r = 0; r < 6; r++) begin
      a_dir = 1'($urandom_range(0, 1));
      for (int i = 0; i < FA; i++) begin
        lv_a[i] = D'($urandom_range(0, 16'hffff));
        sh_a[i] = $urandom_range(0, 2*D);
      end
      start_a();
      wait_done_a(1'b1);
    end
    check_drained_a("random", d0 + 6);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_en = 1'b0; a_dir = 1'b0; a_out_ready = 1'b0; a_level = '0; a_shift = '0;
    b_start = 1'b0; b_en = 1'b0; b_dir = 1'b0; b_out_ready = 1'b0; b_level = '0; b_shift = '0;
    for (int i = 0; i < FA; i++) begin
      lv_a[i] = '0; sh_a[i] = DEFAULT_SHIFT[i];
      lv_b[i] = '0; sh_b[i] = DEFAULT_SHIFT[i];
    end
    test_reset();
    test_basic();
    test_boundary();
    test_modulo();
    test_narrow();
    test_backpressure();
    test_pause();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/enc_binder_array.md
ENC_BINDER_ARRAY -- requirements
Module: enc_binder_array

Interface
REQ-001 SHALL have parameter HV_DIM, default 1024, hypervector width in bits.
REQ-002 SHALL have parameter FEATURES, default 8, level hypervectors bound per encoding.
REQ-003 SHALL have parameter LANES, default 4, physical rotators; BEATS = ceil(FEATURES/LANES); SHIFT_W = clog2(HV_DIM).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  encoding request, sampled in IDLE only.
REQ-007 SHALL have port en  input  1  run-enable; gates start and pauses beat generation.
REQ-008 SHALL have port dir  input  1  rotate direction, 0 = left, 1 = right.
REQ-009 SHALL have port level_hv  input  FEATURES x HV_DIM  level hypervectors.
REQ-010 SHALL have port shift_amt  input  FEATURES x SHIFT_W  per-feature rotate amount.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port out_valid  output  1  output beat valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts beat.
REQ-014 SHALL have port out_hv  output  LANES x HV_DIM  bound hypervectors of current beat.
REQ-015 SHALL have port out_lane_valid  output  LANES  per-lane valid mask.
REQ-016 SHALL have port out_beat  output  clog2(BEATS) (min 1)  beat index.
REQ-017 SHALL have port out_last  output  1  marks final beat.
REQ-018 SHALL have port done  output  1  one-cycle pulse when final beat is accepted.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, FLUSH.
REQ-020 SHALL, in IDLE with start && en at edge k, snapshot level_hv, shift_amt and dir, set beat counter to 0 and enter RUN.
REQ-021 SHALL ignore start when not in IDLE; snapshot SHALL NOT change until return to IDLE.
REQ-022 SHALL, in RUN, load beat b into the output register when en && (!out_valid || out_ready); the first beat is valid after edge k+1 (latency 2 cycles from start).
REQ-023 SHALL compute lane j of beat b from feature i = b*LANES+j: left rotate gives out[n] = in[(n - s) mod HV_DIM]; right rotate gives out[n] = in[(n + s) mod HV_DIM], with s = shift_amt[i] mod HV_DIM.
REQ-024 SHALL, for lanes with i >= FEATURES, drive out_hv lane to all-zero and clear the matching out_lane_valid bit.
REQ-025 SHALL hold out_hv, out_lane_valid, out_beat and out_last stable while out_valid && !out_ready.
REQ-026 SHALL, when en is low in RUN, load no new beat; a pending valid beat remains presented and may still be accepted.
REQ-027 SHALL assert out_last with beat BEATS-1; after loading it, enter FLUSH.
REQ-028 SHALL, in FLUSH, on out_valid && out_ready: deassert out_valid, pulse done for one cycle, and return to IDLE.
REQ-029 SHALL sustain one beat per cycle when out_ready is held high and en is high (throughput 1 beat/cycle).
REQ-030 SHALL treat shift 0 as identity and shift HV_DIM-1 as a one-position rotate in the opposite direction.

Reset
REQ-031 SHALL, with rst high at an edge, force IDLE, clear the beat counter, and drive out_valid, out_last, done, busy, out_lane_valid and out_beat to 0 and out_hv to all-zero.
REQ-032 SHALL abort any encoding in progress on reset; no done pulse is produced and no partial beat remains valid after that edge.
REQ-033 SHALL give rst priority over start in the same cycle.

Structure
REQ-034 SHALL take HV_DIM, the FEATURES_PER_CC default, the default shift table and the FSM state typedef from the shared encoder package.
REQ-035 SHALL instantiate LANES copies of sub-module enc_rotator, a combinational barrel rotator with inputs hv, amt and dir, all driven from the snapshot registers.

Verification
REQ-036 SHALL cover: HV_DIM=16, FEATURES=8, LANES=4, dir=0, shift_amt[i]=i, level_hv[i]=16'h0001, out_ready=1 -> beat0 lanes = 0001,0002,0004,0008; beat1 lanes = 0010..0080; out_last on beat1; done pulses once.
REQ-037 SHALL cover: FEATURES=6, LANES=4 -> beat1 out_lane_valid=4'b0011, lanes 2-3 zero, out_last=1.
REQ-038 SHALL cover: dir=1, shift_amt=17 with HV_DIM=16, hv=16'h0001 -> output 16'h8000 (modulo rule).
REQ-039 SHALL cover: out_ready low for 5 cycles on beat0 -> outputs stable and a second start ignored; after release, remaining beats follow back-to-back.
REQ-040 SHALL cover: en dropped for 3 cycles mid-RUN -> no new beats during the pause; sequence resumes with an unchanged beat index.
REQ-041 SHALL cover: rst asserted during beat1 -> next cycle out_valid=0, busy=0, no done; a new start then restarts from beat0.
